// File: rtl/cflog_writer.sv
// cflog_writer: buffers control-flow events and writes src/dst word pairs into the CF-Log memory.
// Optional macro CFLOG_DROP_COUNT_EN adds the drop_cnt refused-event counter port.
module cflog_writer #(
    parameter logic [15:0] LOG_BASE   = 16'h01b0,
    parameter logic [15:0] LOG_SIZE   = 16'h0080,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ev_valid,
    input  logic [15:0] ev_src,
    input  logic [15:0] ev_dst,
    output logic        ev_ready,
    output logic [15:0] log_addr,
    output logic [15:0] log_data,
    output logic        log_wen,
    output logic [15:0] log_ptr,
    output logic        log_full,
    input  logic        flush_ack
`ifdef CFLOG_DROP_COUNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, WR_SRC, WR_DST, FULL} state_t;
    state_t state, state_n;
    logic [15:0] src_mem [FIFO_DEPTH];
    logic [15:0] dst_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [15:0] wr_addr;
    logic        push, pop, flush;
    assign count    = wr_ptr - rd_ptr;
    assign ev_ready = count != (AW+1)'(FIFO_DEPTH);
    assign push     = ev_valid && ev_ready;
    assign flush    = state == FULL && flush_ack;
    assign log_full = state == FULL;
    assign wr_addr  = LOG_BASE + (log_ptr << 1);
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        log_wen  = 1'b0;
        log_addr = '0;
        log_data = '0;
        case (state)
            IDLE: state_n = count != '0 ? WR_SRC : IDLE;
            WR_SRC: begin
                log_wen  = 1'b1;
                log_addr = wr_addr;
                log_data = src_mem[rd_ptr[AW-1:0]];
                state_n  = WR_DST;
            end
            WR_DST: begin
                log_wen  = 1'b1;
                log_addr = wr_addr;
                log_data = dst_mem[rd_ptr[AW-1:0]];
                pop      = 1'b1;
                // the entry being popped this cycle does not count toward another write
                state_n  = log_ptr + 16'd1 == LOG_SIZE ? FULL :
                           count > (AW+1)'(1) ? WR_SRC : IDLE;
            end
            FULL: state_n = flush_ack ? IDLE : FULL;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_ptr <= '0;
        end else begin
            state   <= state_n;
            wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
            log_ptr <= flush ? '0 : log_wen ? log_ptr + 16'd1 : log_ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr[AW-1:0]] <= ev_src;
            dst_mem[wr_ptr[AW-1:0]] <= ev_dst;
        end
    end
`ifdef CFLOG_DROP_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_cnt <= '0;
        else if (flush)
            drop_cnt <= '0;
        else if (ev_valid && !ev_ready && drop_cnt != 16'hffff)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_cflog_writer.sv
// tb_cflog_writer: directed + randomized checks of cflog_writer against a word-queue log model.
module tb_cflog_writer;
    localparam logic [15:0] LOG_BASE = 16'h01b0;
    localparam int LOG_SIZE = 128;
    localparam int DEPTH = 4;
    logic clk, reset_n, ev_valid, ev_ready, log_wen, log_full, flush_ack;
    logic [15:0] ev_src, ev_dst, log_addr, log_data, log_ptr;
`ifdef CFLOG_DROP_COUNT_EN
    logic [15:0] drop_cnt;
`endif
    int total = 0, bad = 0;
    logic [15:0] wq[$];
    int ptr = 0, occ = 0, drops = 0;
    int writes, n;
    logic [15:0] last_addr;

    cflog_writer dut (
        .clk(clk), .reset_n(reset_n), .ev_valid(ev_valid), .ev_src(ev_src), .ev_dst(ev_dst),
        .ev_ready(ev_ready), .log_addr(log_addr), .log_data(log_data), .log_wen(log_wen),
        .log_ptr(log_ptr), .log_full(log_full), .flush_ack(flush_ack)
`ifdef CFLOG_DROP_COUNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        ptr = 0;
        occ = 0;
        drops = 0;
    endtask

    // one cycle from a negedge: drive, check, then advance the model across the posedge
    task automatic step(input logic v, input logic [15:0] s, input logic [15:0] d, input logic f);
        logic acc, wrote, full_b, rdy;
        ev_valid = v; ev_src = s; ev_dst = d; flush_ack = f;
        #1;
        rdy    = occ < DEPTH;
        full_b = ptr == LOG_SIZE;
        check("ev_ready", 16'(ev_ready), 16'(rdy));
        check("log_ptr", log_ptr, 16'(ptr));
        check("log_full", 16'(log_full), 16'(full_b));
`ifdef CFLOG_DROP_COUNT_EN
        check("drop_cnt", drop_cnt, 16'(drops));
`endif
        if (ptr % 2 == 1)
            check("dst_follows_src", 16'(log_wen), 16'd1);
        if (log_wen) begin
            check("write_allowed", 16'(wq.size() > 0 && !full_b), 16'd1);
            if (wq.size() > 0) begin
                check("log_addr", log_addr, LOG_BASE + 16'(2 * ptr));
                check("log_data", log_data, wq[0]);
            end
        end else begin
            check("idle_addr", log_addr, 16'h0000);
            check("idle_data", log_data, 16'h0000);
        end
        acc   = v && rdy;
        wrote = log_wen && wq.size() > 0 && !full_b;
        @(posedge clk);
        if (wrote) begin
            void'(wq.pop_front());
            if (ptr % 2 == 1) occ--;
            ptr++;
        end
        if (acc) begin
            wq.push_back(s);
            wq.push_back(d);
            occ++;
        end
        if (v && !rdy && drops < 65535) drops++;
        if (f && full_b) begin
            ptr = 0;
            drops = 0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        while (wq.size() > 0 && ptr < LOG_SIZE && k < 300) begin
            step(1'b0, 16'h0, 16'h0, 1'b0);
            k++;
        end
        check("drain_bound", 16'(k < 300), 16'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"}, 16'(log_wen), 16'd0);
        check({tag, "_addr"}, log_addr, 16'h0000);
        check({tag, "_data"}, log_data, 16'h0000);
        check({tag, "_ptr"}, log_ptr, 16'h0000);
        check({tag, "_full"}, 16'(log_full), 16'd0);
        check({tag, "_ready"}, 16'(ev_ready), 16'd1);
`ifdef CFLOG_DROP_COUNT_EN
        check({tag, "_drop"}, drop_cnt, 16'h0000);
`endif
    endtask

    initial begin
        reset_n = 1'b0; ev_valid = 1'b0; ev_src = '0; ev_dst = '0; flush_ack = 1'b0;
        #3;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        // single event from IDLE
        step(1'b1, 16'h4400, 16'h4520, 1'b0);
        n = 0;
        while (!log_wen && n < 20) begin
            step(1'b0, 16'h0, 16'h0, 1'b0);
            n++;
        end
        check("one_src_data", log_data, 16'h4400);
        check("one_src_addr", log_addr, 16'h01b0);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        check("one_dst_wen", 16'(log_wen), 16'd1);
        check("one_dst_data", log_data, 16'h4520);
        check("one_dst_addr", log_addr, 16'h01b2);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        check("one_ptr", log_ptr, 16'd2);
        // flush outside FULL is ignored
        step(1'b0, 16'h0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        check("idle_flush_ptr", log_ptr, 16'd2);
        // restart clean for the fill test
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst2");
        @(negedge clk);
        reset_n = 1'b1;
        writes = 0;
        last_addr = '0;
        n = 0;
        while (ptr < LOG_SIZE && n < 1000) begin
            if (log_wen) begin
                writes++;
                last_addr = log_addr;
            end
            step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
            n++;
        end
        check("fill_writes", 16'(writes), 16'd128);
        check("fill_last_addr", last_addr, 16'h02ae);
        check("fill_full", 16'(log_full), 16'd1);
        repeat (14) step(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        check("full_ready", 16'(ev_ready), 16'd0);
        check("full_ptr", log_ptr, 16'd128);
        // flush: the four buffered events land from LOG_BASE in order
        step(1'b0, 16'h0, 16'h0, 1'b1);
        check("flush_ptr", log_ptr, 16'd0);
        check("flush_full", 16'(log_full), 16'd0);
        drain();
        check("after_flush_ptr", log_ptr, 16'd8);
        // randomized traffic with occasional flush pulses
        repeat (1500)
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 15) == 0));
        if (ptr == LOG_SIZE) step(1'b0, 16'h0, 16'h0, 1'b1);
        // reset while a dst write is pending
        step(1'b1, 16'hbeef, 16'hcafe, 1'b0);
        n = 0;
        while (!(log_wen && ptr % 2 == 0) && n < 50) begin
            step(1'b0, 16'h0, 16'h0, 1'b0);
            n++;
        end
        step(1'b0, 16'h0, 16'h0, 1'b0);
        check("pre_rst_in_dst", 16'(log_wen && ptr % 2 == 1), 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst3");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) step(1'b0, 16'h0, 16'h0, 1'b0);
        check("post_rst_ptr", log_ptr, 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
